// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write bus between the UART program loader and the
// FPU core's instruction memory.
//   imem_we_o    : one-cycle write strobe
//   imem_addr_o  : word address (ADDR_W bits)
//   imem_wdata_o : 32-bit instruction word
// master = loader (drives the bus), slave = memory side.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;

  modport master (output imem_we_o, imem_addr_o, imem_wdata_o);
  modport slave  (input  imem_we_o, imem_addr_o, imem_wdata_o);
endinterface

// File: rtl/uart_prog_loader.sv
// UART program loader: receive end of the host program-load link.
// Deserialises 8N1 frames from rx_i, packs four bytes little-endian into a
// 32-bit word and writes each word to instruction memory at consecutive
// addresses. The sentinel word END_WORD ends the load (never written).
// Ports:
//   wb_clk_i     system clock
//   wb_rst_i     asynchronous reset, active high
//   en_i         load enable; low holds the receiver idle and drops a partial word
//   rx_i         UART serial input, idle high
//   imem         instruction-memory write bus (master side)
//   prog_done_o  sticky: sentinel received
//   frame_err_o  sticky: a stop bit was sampled low
// CLKS_PER_BIT must be >= 4.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] END_WORD     = 32'h00000FFF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               en_i,
  input  logic               rx_i,
  uart_prog_loader_if.master imem,
  output logic               prog_done_o,
  output logic               frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_req_t;

  state_t            state_q, state_d;
  logic              rx_meta_q, rx_sync_q;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  wr_req_t           wr_q, wr_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  // After a bad stop bit the line may still be low; a start bit is only
  // armed again once the line has been seen high.
  logic              wait_hi_q, wait_hi_d;

  // 2-flop synchroniser, idles high
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wr_q       <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      wait_hi_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      we_q       <= we_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      wait_hi_q  <= wait_hi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    we_d       = 1'b0;
    done_d     = done_q;
    ferr_d     = ferr_q;
    wait_hi_d  = wait_hi_q;

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (wait_hi_q) begin
          if (rx_sync_q) wait_hi_d = 1'b0;
        end else if (!done_q && !rx_sync_q) begin
          state_d = START;
        end
      end

      // Resample mid start bit; a high line here was a glitch.
      START: begin
        if (clk_cnt_q == HALF_END) begin
          clk_cnt_d = '0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          if (rx_sync_q) begin
            word_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == 2'd3) begin
              state_d = WRITE;
              // Strobe is registered so it is high exactly during WRITE;
              // the captured addr/data hold until the next write.
              if (word_d != END_WORD) begin
                we_d   = 1'b1;
                wr_d   = '{addr: addr_q, data: word_d};
                addr_d = addr_q + 1'b1;
              end
            end else begin
              state_d = IDLE;
            end
          end else begin
            ferr_d    = 1'b1;
            wait_hi_d = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      WRITE: begin
        if (word_q == END_WORD) done_d = 1'b1;
        byte_cnt_d = '0;
        word_d     = '0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Disable wins over everything: drop the partial word, keep address and flags.
    if (!en_i) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
      word_d     = '0;
      we_d       = 1'b0;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wait_hi_d  = 1'b0;
    end
  end

  assign imem.imem_we_o    = we_q;
  assign imem.imem_addr_o  = wr_q.addr;
  assign imem.imem_wdata_o = wr_q.data;
  assign prog_done_o       = done_q;
  assign frame_err_o       = ferr_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;
  localparam int          CPB  = 8;
  localparam logic [31:0] ENDW = 32'h00000FFF;
  localparam int          LOGN = 1024;

  logic clk = 1'b0;
  logic rst, en, rx;
  logic done_a, ferr_a, done_b, ferr_b;

  always #5 clk = ~clk;

  uart_prog_loader_if #(.ADDR_W(10)) bus_a ();
  uart_prog_loader_if #(.ADDR_W(2))  bus_b ();

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(10), .END_WORD(ENDW)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .rx_i(rx),
    .imem(bus_a), .prog_done_o(done_a), .frame_err_o(ferr_a));

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2), .END_WORD(ENDW)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .rx_i(rx),
    .imem(bus_b), .prog_done_o(done_b), .frame_err_o(ferr_b));

  // ---------------- write monitor (only writer of these) ----------------
  int          cnt_a = 0, cnt_b = 0, run_a = 0, run_b = 0, max_a = 0, max_b = 0;
  logic [31:0] la_addr [LOGN];
  logic [31:0] la_data [LOGN];
  logic [31:0] lb_addr [LOGN];
  logic [31:0] lb_data [LOGN];

  always @(negedge clk) begin
    if (bus_a.imem_we_o) begin
      if (cnt_a < LOGN) begin
        la_addr[cnt_a] = 32'(bus_a.imem_addr_o);
        la_data[cnt_a] = bus_a.imem_wdata_o;
      end
      cnt_a = cnt_a + 1;
      run_a = run_a + 1;
      if (run_a > max_a) max_a = run_a;
    end else run_a = 0;
    if (bus_b.imem_we_o) begin
      if (cnt_b < LOGN) begin
        lb_addr[cnt_b] = 32'(bus_b.imem_addr_o);
        lb_data[cnt_b] = bus_b.imem_wdata_o;
      end
      cnt_b = cnt_b + 1;
      run_b = run_b + 1;
      if (run_b > max_b) max_b = run_b;
    end else run_b = 0;
  end

  // ---------------- reference model: byte stream -> expected writes ----------------
  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t        expa[$];
  wr_t        expb[$];
  logic [7:0] m_bytes[$];
  int         m_addr;
  bit         m_done, m_ferr;
  int         rd_a = 0, rd_b = 0;
  int         total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    m_addr = 0;
    m_done = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    logic [31:0] w;
    if (m_done) return;
    if (!ok) begin
      m_ferr = 1'b1;
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      m_bytes.delete();
      if (w == ENDW) m_done = 1'b1;
      else begin
        expa.push_back('{m_addr % 1024, w});
        expb.push_back('{m_addr % 4, w});
        m_addr++;
      end
    end
  endtask

  // Compare everything the monitor logged against the model's expectations.
  task automatic sync_check();
    wr_t e;
    while (rd_a < cnt_a && rd_a < LOGN) begin
      if (expa.size() == 0) begin
        total++; bad++;
        $display("FAIL strobe_a: unexpected write addr %0h data %0h", la_addr[rd_a], la_data[rd_a]);
      end else begin
        e = expa.pop_front();
        chk("addr_a", la_addr[rd_a], 32'(e.addr));
        chk("data_a", la_data[rd_a], e.data);
      end
      rd_a++;
    end
    while (rd_b < cnt_b && rd_b < LOGN) begin
      if (expb.size() == 0) begin
        total++; bad++;
        $display("FAIL strobe_b: unexpected write addr %0h data %0h", lb_addr[rd_b], lb_data[rd_b]);
      end else begin
        e = expb.pop_front();
        chk("addr_b", lb_addr[rd_b], 32'(e.addr));
        chk("data_b", lb_data[rd_b], e.data);
      end
      rd_b++;
    end
    chk("missing_writes_a", 32'(expa.size()), 32'd0);
    chk("missing_writes_b", 32'(expb.size()), 32'd0);
    chk("done_a", 32'(done_a), 32'(m_done));
    chk("done_b", 32'(done_b), 32'(m_done));
    chk("ferr_a", 32'(ferr_a), 32'(m_ferr));
    chk("ferr_b", 32'(ferr_b), 32'(m_ferr));
  endtask

  // ---------------- stimulus ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0; wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; wait_clks(CPB);
    end
    rx = stop_ok; wait_clks(CPB);
    rx = 1'b1; wait_clks(2 * CPB);
    model_byte(b, stop_ok);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we_a"},    32'(bus_a.imem_we_o),   32'd0);
    chk({tag, "_addr_a"},  32'(bus_a.imem_addr_o), 32'd0);
    chk({tag, "_wdata_a"}, bus_a.imem_wdata_o,     32'd0);
    chk({tag, "_done_a"},  32'(done_a),            32'd0);
    chk({tag, "_ferr_a"},  32'(ferr_a),            32'd0);
    chk({tag, "_addr_b"},  32'(bus_b.imem_addr_o), 32'd0);
    chk({tag, "_wdata_b"}, bus_b.imem_wdata_o,     32'd0);
  endtask

  task automatic do_reset(input bit check, input string tag);
    rst = 1'b1;
    wait_clks(3);
    if (check) check_zero(tag);
    rx = 1'b1; en = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    model_reset();
    wait_clks(2);
  endtask

  task automatic en_drop();
    en = 1'b0; wait_clks(3);
    en = 1'b1; wait_clks(2);
    m_bytes.delete();
  endtask

  task automatic glitch();
    rx = 1'b0; wait_clks(2);
    rx = 1'b1; wait_clks(3 * CPB);
  endtask

  typedef struct {
    bit          rst_first;
    logic [31:0] word;
    logic [31:0] addr_a;
    logic [31:0] addr_b;
    logic [31:0] data;
    bit          done;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int op;
    // last bus value expected while done is set: sentinel and later frames write nothing
    tbl[0] = '{1'b0, 32'h00000513, 32'd0, 32'd0, 32'h00000513, 1'b0};
    tbl[1] = '{1'b1, 32'h00100093, 32'd0, 32'd0, 32'h00100093, 1'b0};
    tbl[2] = '{1'b0, 32'h00208113, 32'd1, 32'd1, 32'h00208113, 1'b0};
    tbl[3] = '{1'b0, 32'h00000FFF, 32'd1, 32'd1, 32'h00208113, 1'b1};
    tbl[4] = '{1'b0, 32'hDEADBEEF, 32'd1, 32'd1, 32'h00208113, 1'b1};
    tbl[5] = '{1'b1, 32'h11111111, 32'd0, 32'd0, 32'h11111111, 1'b0};
    tbl[6] = '{1'b0, 32'h22222222, 32'd1, 32'd1, 32'h22222222, 1'b0};
    tbl[7] = '{1'b0, 32'h33333333, 32'd2, 32'd2, 32'h33333333, 1'b0};
    tbl[8] = '{1'b0, 32'h44444444, 32'd3, 32'd3, 32'h44444444, 1'b0};
    tbl[9] = '{1'b0, 32'h55555555, 32'd4, 32'd0, 32'h55555555, 1'b0};

    rst = 1'b1; en = 1'b1; rx = 1'b1;
    model_reset();
    wait_clks(1);
    do_reset(1'b1, "reset");

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst_first) do_reset(1'b0, "");
      send_word(tbl[i].word);
      chk($sformatf("tbl%0d_addr_a", i), 32'(bus_a.imem_addr_o), tbl[i].addr_a);
      chk($sformatf("tbl%0d_addr_b", i), 32'(bus_b.imem_addr_o), tbl[i].addr_b);
      chk($sformatf("tbl%0d_data_a", i), bus_a.imem_wdata_o, tbl[i].data);
      chk($sformatf("tbl%0d_data_b", i), bus_b.imem_wdata_o, tbl[i].data);
      chk($sformatf("tbl%0d_done", i), 32'(done_a), 32'(tbl[i].done));
      sync_check();
    end

    // glitch on the start bit: nothing recorded, next word lands at 0
    do_reset(1'b0, "");
    glitch();
    chk("glitch_ferr", 32'(ferr_a), 32'd0);
    chk("glitch_nowrite", 32'(cnt_a - rd_a), 32'd0);
    send_word(32'hCAFE0001);
    chk("glitch_next_addr", 32'(bus_a.imem_addr_o), 32'd0);
    sync_check();

    // bad stop bit drops the byte, the next four bytes form the word
    send_byte(8'h77, 1'b0);
    chk("ferr_set", 32'(ferr_a), 32'd1);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
    chk("ferr_word", bus_a.imem_wdata_o, 32'hDDCCBBAA);
    chk("ferr_addr", 32'(bus_a.imem_addr_o), 32'd1);
    sync_check();

    // reset in the data bits of the third byte
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    rx = 1'b0; wait_clks(CPB);
    rx = 1'b1; wait_clks(3 * CPB);
    do_reset(1'b1, "midrst");
    send_word(32'h12345678);
    chk("midrst_addr", 32'(bus_a.imem_addr_o), 32'd0);
    chk("midrst_data", bus_a.imem_wdata_o, 32'h12345678);
    sync_check();

    // enable drop discards a partial word, keeps the address
    send_byte(8'hEE, 1'b1); send_byte(8'hFF, 1'b1);
    en_drop();
    send_word(32'h0BADF00D);
    chk("endrop_data", bus_a.imem_wdata_o, 32'h0BADF00D);
    chk("endrop_addr", 32'(bus_a.imem_addr_o), 32'd1);
    sync_check();

    // random mix of good bytes, bad stop bits, glitches and enable drops
    do_reset(1'b0, "");
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 99));
      if (op < 80)      send_byte(8'($urandom), 1'b1);
      else if (op < 88) send_byte(8'($urandom), 1'b0);
      else if (op < 94) glitch();
      else              en_drop();
      sync_check();
    end

    chk("strobe_width_a", 32'(max_a), 32'd1);
    chk("strobe_width_b", 32'(max_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
